// File: rtl/chimera_pkg.sv
// Shared SoC types: APB request/response and the cluster power-sequencer
// register offsets, state encoding and per-state output decode.
package chimera_pkg;

    typedef struct packed {
        logic [31:0] paddr;
        logic [2:0]  pprot;
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
    } apb_req_t;

    typedef struct packed {
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
    } apb_resp_t;

    localparam int unsigned ExtClusters = 5;

    localparam logic [11:0] PwrCtrlOffset   = 12'h000;
    localparam logic [11:0] PwrStatusOffset = 12'h004;
    localparam logic [11:0] PwrBusyOffset   = 12'h008;
    localparam logic [11:0] PwrErrOffset    = 12'h00C;

    typedef enum logic [2:0] {
        PWR_OFF, PWR_CLK_ON, PWR_RST_REL, PWR_DEISO,
        PWR_ON, PWR_ISO, PWR_RST, PWR_CLK_OFF
    } cluster_pwr_state_e;

    // {iso, clk_en, rst_n} driven while the sequencer sits in a state
    function automatic logic [2:0] pwr_state_outs(cluster_pwr_state_e s);
        case (s)
            PWR_CLK_ON, PWR_RST:  return 3'b110;
            PWR_RST_REL, PWR_ISO: return 3'b111;
            PWR_DEISO, PWR_ON:    return 3'b011;
            default:              return 3'b100;
        endcase
    endfunction

endpackage

// File: rtl/chimera_cluster_pwr_ctrl_fsm.sv
// Single-cluster power sequencer: clock enable, reset release and AXI
// isolation handshake, with one shared settle/timeout counter.
module chimera_cluster_pwr_fsm
    import chimera_pkg::*;
#(
    parameter int unsigned ClkSettleCycles = 4,
    parameter int unsigned IsoTimeout      = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic target_i,
    input  logic isolated_i,
    output logic iso_o,
    output logic clk_en_o,
    output logic rst_no,
    output logic on_o,
    output logic busy_o,
    output logic timeout_o,
    output logic force_on_o
);

    localparam int unsigned CntMax = (ClkSettleCycles > IsoTimeout) ? ClkSettleCycles : IsoTimeout;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] SettleLast = CntW'(ClkSettleCycles - 1);
    localparam logic [CntW-1:0] TimeoutCnt = CntW'(IsoTimeout);
    localparam logic [CntW-1:0] CntSat     = CntW'(CntMax);

    cluster_pwr_state_e state_d, state_q;
    logic [CntW-1:0]    cnt_d, cnt_q;
    logic [2:0]         outs_d, outs_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q == CntSat) ? cnt_q : cnt_q + CntW'(1);
        timeout_o  = 1'b0;
        force_on_o = 1'b0;
        case (state_q)
            PWR_OFF:     if (target_i) state_d = PWR_CLK_ON;
            PWR_CLK_ON:  if (cnt_q == SettleLast) state_d = PWR_RST_REL;
            PWR_RST_REL: state_d = PWR_DEISO;
            // An acknowledge arriving on the timeout cycle takes priority
            PWR_DEISO: begin
                if (!isolated_i) begin
                    state_d = PWR_ON;
                end else if (cnt_q == TimeoutCnt) begin
                    timeout_o = 1'b1;
                    state_d   = PWR_ISO;
                end
            end
            PWR_ON:      if (!target_i) state_d = PWR_ISO;
            PWR_ISO: begin
                if (isolated_i) begin
                    state_d = PWR_RST;
                end else if (cnt_q == TimeoutCnt) begin
                    timeout_o  = 1'b1;
                    force_on_o = 1'b1;
                    state_d    = PWR_ON;
                end
            end
            PWR_RST:     state_d = PWR_CLK_OFF;
            PWR_CLK_OFF: state_d = PWR_OFF;
            default:     state_d = PWR_OFF;
        endcase
        if (state_d != state_q) cnt_d = '0;
        outs_d = pwr_state_outs(state_d);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= PWR_OFF;
            cnt_q   <= '0;
            outs_q  <= 3'b100;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            outs_q  <= outs_d;
        end
    end

    assign {iso_o, clk_en_o, rst_no} = outs_q;
    assign on_o   = (state_q == PWR_ON);
    assign busy_o = (state_q != PWR_ON) && (state_q != PWR_OFF);

endmodule

// File: rtl/chimera_cluster_pwr_ctrl.sv
// APB register front end for the per-cluster power sequencers: CTRL target,
// STATUS/BUSY views and sticky timeout flags.
module chimera_cluster_pwr_ctrl
    import chimera_pkg::*;
#(
    parameter int unsigned NumClusters     = ExtClusters,
    parameter int unsigned ClkSettleCycles = 4,
    parameter int unsigned IsoTimeout      = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  apb_req_t               apb_req_i,
    output apb_resp_t              apb_rsp_o,
    output logic [NumClusters-1:0] cluster_iso_o,
    input  logic [NumClusters-1:0] cluster_isolated_i,
    output logic [NumClusters-1:0] cluster_clk_en_o,
    output logic [NumClusters-1:0] cluster_rst_no,
    output logic                   err_irq_o
);

    logic [NumClusters-1:0] ctrl_d, ctrl_q, err_d, err_q;
    logic [NumClusters-1:0] on, busy, timeout, force_on, reg_sel;
    logic [NumClusters-1:0] wdata;
    logic [11:0]            reg_offs;
    logic                   access, reg_valid, wr_ctrl, wr_err;
    logic                   unused_apb;

    assign reg_offs   = apb_req_i.paddr[11:0];
    assign wdata      = apb_req_i.pwdata[NumClusters-1:0];
    assign access     = apb_req_i.psel && apb_req_i.penable;
    assign wr_ctrl    = access && apb_req_i.pwrite && (reg_offs == PwrCtrlOffset);
    assign wr_err     = access && apb_req_i.pwrite && (reg_offs == PwrErrOffset);
    assign unused_apb = ^{apb_req_i.paddr[31:12], apb_req_i.pprot, apb_req_i.pstrb, apb_req_i.pwdata};

    always_comb begin
        reg_sel   = '0;
        reg_valid = 1'b1;
        case (reg_offs)
            PwrCtrlOffset:   reg_sel = ctrl_q;
            PwrStatusOffset: reg_sel = on;
            PwrBusyOffset:   reg_sel = busy;
            PwrErrOffset:    reg_sel = err_q;
            default:         reg_valid = 1'b0;
        endcase
    end

    // A failed power-down forces the target back on; new timeouts beat W1C
    always_comb begin
        ctrl_d = wr_ctrl ? wdata : ctrl_q;
        ctrl_d = ctrl_d | force_on;
        err_d  = wr_err ? (err_q & ~wdata) : err_q;
        err_d  = err_d | timeout;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_q <= '0;
            err_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            err_q  <= err_d;
        end
    end

    assign apb_rsp_o.pready  = 1'b1;
    assign apb_rsp_o.pslverr = access && !reg_valid;
    assign apb_rsp_o.prdata  = (apb_req_i.psel && !apb_req_i.pwrite && reg_valid) ? 32'(reg_sel) : 32'd0;
    assign err_irq_o         = |err_q;

    for (genvar i = 0; i < NumClusters; i++) begin : gen_fsm
        chimera_cluster_pwr_fsm #(
            .ClkSettleCycles (ClkSettleCycles),
            .IsoTimeout      (IsoTimeout)
        ) i_fsm (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .target_i   (ctrl_q[i]),
            .isolated_i (cluster_isolated_i[i]),
            .iso_o      (cluster_iso_o[i]),
            .clk_en_o   (cluster_clk_en_o[i]),
            .rst_no     (cluster_rst_no[i]),
            .on_o       (on[i]),
            .busy_o     (busy[i]),
            .timeout_o  (timeout[i]),
            .force_on_o (force_on[i])
        );
    end

endmodule
